// File: rtl/cntr8_seq_if.sv
// Request/response bundle for the 8-bit counter sequencer.
// The master drives requests and load data. The slave returns state, count and wrap.
interface cntr8_seq_if;
  logic       clr;
  logic       load;
  logic       inc;
  logic       dec;
  logic [7:0] d_in;
  logic [2:0] state;
  logic [7:0] d_out;
  logic       wrap;

  modport master (
    output clr, load, inc, dec, d_in,
    input  state, d_out, wrap
  );

  modport slave (
    input  clr, load, inc, dec, d_in,
    output state, d_out, wrap
  );
endinterface

// File: rtl/cntr8_seq.sv
// Sequencer for the 8-bit counter datapath: prioritised request decode,
// registered state/count, and a one-cycle wrap pulse.
//
// state       | meaning
// ------------+------------------------------------------
// IDLE_STATE  | count cleared / post-reset
// LOAD_STATE  | count loaded from d_in
// INC_STATE   | increment step, even phase
// INC2_STATE  | increment step, odd phase
// DEC_STATE   | decrement step, even phase
// DEC2_STATE  | decrement step, odd phase
// HOLD_STATE  | count held, no request
// ILLEGAL     | unreachable; recovers to IDLE_STATE
module cntr8_seq (
  input  logic       clk,
  input  logic       reset_n,
  cntr8_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE_STATE    = 3'b000,
    LOAD_STATE    = 3'b001,
    INC_STATE     = 3'b010,
    INC2_STATE    = 3'b011,
    DEC_STATE     = 3'b100,
    DEC2_STATE    = 3'b101,
    HOLD_STATE    = 3'b110,
    ILLEGAL_STATE = 3'b111
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic       wrap_q,  wrap_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (state_q == ILLEGAL_STATE) begin
      state_d = IDLE_STATE;
      count_d = 8'h00;
    end else if (bus.clr) begin
      state_d = IDLE_STATE;
      count_d = 8'h00;
    end else if (bus.load) begin
      state_d = LOAD_STATE;
      count_d = bus.d_in;
    end else if (bus.inc) begin
      // Phase flips only while the same request persists; any other prior state restarts even.
      state_d = (state_q == INC_STATE) ? INC2_STATE : INC_STATE;
      count_d = count_q + 8'd1;
      wrap_d  = (count_q == 8'hFF);
    end else if (bus.dec) begin
      state_d = (state_q == DEC_STATE) ? DEC2_STATE : DEC_STATE;
      count_d = count_q - 8'd1;
      wrap_d  = (count_q == 8'h00);
    end else begin
      state_d = (state_q == IDLE_STATE) ? IDLE_STATE : HOLD_STATE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE_STATE;
      count_q <= 8'h00;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.state = state_q;
  assign bus.d_out = count_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: doc/cntr8_seq.md
Name: cntr8_seq

Overview:
- Sequencer for the 8-bit counter datapath. It owns the 3-bit counter state register and the 8-bit count register.
- It decodes the clear, load, increment and decrement requests into the state encoding that the output-select logic consumes.
- It sits directly in front of the counter output stage and exports the current state and count, plus a wrap indicator for downstream event logic.

Parameters:
- IDLE_STATE, 3'b000, count cleared / post-reset state
- LOAD_STATE, 3'b001, count loaded from d_in
- INC_STATE, 3'b010, increment step, even phase
- INC2_STATE, 3'b011, increment step, odd phase
- DEC_STATE, 3'b100, decrement step, even phase
- DEC2_STATE, 3'b101, decrement step, odd phase
- HOLD_STATE, 3'b110, count held, no request
- All encodings are distinct; 3'b111 is illegal.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- clr  input  1  synchronous clear request
- load  input  1  load request; count takes d_in
- inc  input  1  increment request
- dec  input  1  decrement request
- d_in  input  8  load value
- state  output  3  current state register, one of the encodings above
- d_out  output  8  current count register
- wrap  output  1  one-cycle pulse, count wrapped on the last edge

Behaviour:
- Reset (reset_n=0, asynchronous, takes effect immediately regardless of clk):
  - state=IDLE_STATE, d_out=8'h00, wrap=0.
  - Release is sampled on the next rising clk edge.
- Request priority, evaluated each edge: clr > load > inc > dec > none. Simultaneous requests resolve by this priority only; lower requests are ignored that cycle.
- Next-state rules, identical from every current state:
  - clr → IDLE_STATE.
  - load → LOAD_STATE.
  - inc → INC2_STATE if current state is INC_STATE, else INC_STATE. The state toggles INC/INC2 every cycle while inc is held.
  - dec → DEC2_STATE if current state is DEC_STATE, else DEC_STATE. The state toggles DEC/DEC2 every cycle while dec is held.
  - none → IDLE_STATE if current state is IDLE_STATE, else HOLD_STATE.
- Count update, registered on the same edge as the state and determined by the next state:
  - IDLE: d_out ← 8'h00.
  - LOAD: d_out ← d_in as sampled at the edge.
  - INC / INC2: d_out ← d_out + 1, modulo 256.
  - DEC / DEC2: d_out ← d_out − 1, modulo 256.
  - HOLD: d_out unchanged.
- Latency: a request sampled at edge k is visible on state and d_out immediately after edge k. Sustained inc or dec produces exactly one step per clock.
- wrap, registered:
  - wrap ← 1 for the one cycle after an edge where an increment step starts from 8'hFF (result 8'h00).
  - wrap ← 1 for the one cycle after an edge where a decrement step starts from 8'h00 (result 8'hFF).
  - wrap ← 0 on every other edge, including loads of 8'h00 or 8'hFF and clears.
- Illegal state 3'b111, defensive only: next state is IDLE_STATE, d_out ← 8'h00, wrap ← 0.
- Reset asserted mid-count forces the reset values immediately. The first edge after release follows the normal rules from IDLE_STATE.
- Inputs are treated as synchronous to clk. No internal synchronizers.

Test Plan:
- Reset: assert reset_n=0 mid-run with d_out=8'h5A → state=000 and d_out=00 without waiting for a clock edge; wrap=0.
- Load then increment:
  - load=1, d_in=8'h10 for 1 cycle → state=001, d_out=10.
  - Then inc=1 for 4 cycles → state sequence 010, 011, 010, 011; d_out sequence 11, 12, 13, 14.
  - Then all requests 0 → state=110, d_out holds 14.
- Increment wrap: load 8'hFE, then inc for 3 cycles → d_out FF, 00, 01; wrap=1 only in the cycle d_out=00.
- Decrement wrap: load 8'h01, then dec for 3 cycles → d_out 00, FF, FE; state 100, 101, 100; wrap=1 only in the cycle d_out=FF.
- Priority:
  - From d_out=20: clr=load=inc=dec=1 → state=000, d_out=00.
  - Next cycle load=inc=1, d_in=8'h33 → state=001, d_out=33.
  - Next cycle inc=dec=1 → state=010, d_out=34.
- Idle residency and phase restart:
  - After reset with no requests for 5 cycles → state stays 000, d_out=00.
  - Then inc, dec, inc on consecutive cycles → states 010, 100, 010 (each phase restarts at the even state); d_out 01, 00, 01; wrap=0 throughout.
